qu_run_ctrl: RTL and testbench
==============================

// Module: qu_run_ctrl
// PURPOSE
//  Parametrised run controller wrapping qu_core: sequences core reset, runs it for a cycle budget, merges
//  per-stage stall requests into the core stall, injects PC redirects, drains, then reports done/aborted.
//  Sits between platform/host logic and qu_core. Replaces hand-written reset/stall/pc_override sequencing.
// PARAMETERS
//  PC_WIDTH       32  width of pc_override / redirect_pc (set to QU_PC_WIDTH)
//  NUM_STALL_SRC  4   stall request channels (IF, ID, MP, RN by default)
//  RST_CYCLES     5   cycles core_rst is held high after start (>=1)
//  RUN_CYCLES     20  default budget, used when cfg_run_cycles==0
//  DRAIN_CYCLES   2   cycles stall is forced high after budget expiry (>=1)
//  CNT_WIDTH      16  width of budget/cycle counters
// PORTS
//  clk                input   1              clock, all logic on rising edge
//  rst                input   1              synchronous, active-low reset
//  start              input   1              begin a run (accepted in IDLE or DONE only)
//  abort              input   1              terminate current run
//  cfg_run_cycles     input   CNT_WIDTH      run budget, sampled at accepted start
//  stall_req          input   NUM_STALL_SRC  per-source stall requests
//  redirect_valid     input   1              request PC override
//  redirect_pc        input   PC_WIDTH       target PC
//  core_rst           output  1              reset to qu_core (active-high)
//  stall              output  1              stall to qu_core
//  pc_override_valid  output  1              one-cycle redirect pulse to qu_core
//  pc_override        output  PC_WIDTH       redirect target
//  busy               output  1              high in RESET, RUN, DRAIN
//  done               output  1              high in DONE
//  aborted            output  1              DONE reached via abort
//  cycle_cnt          output  CNT_WIDTH      RUN cycles elapsed, saturating
// BEHAVIOUR
//  Reset (rst==0 at edge): state IDLE, core_rst=1, stall=0, pc_override_valid=0, pc_override=0,
//   busy=0, done=0, aborted=0, cycle_cnt=0. Reset mid-run returns to IDLE immediately, no drain.
//  FSM IDLE->RESET->RUN->DRAIN->DONE; all outputs registered (1-cycle latency from inputs).
//  IDLE: core_rst=1. start -> RESET; budget <= (cfg_run_cycles==0) ? RUN_CYCLES : cfg_run_cycles.
//  RESET: core_rst=1 for exactly RST_CYCLES cycles, then RUN; cycle_cnt cleared on entry.
//  RUN: core_rst=0; stall <= |stall_req; cycle_cnt increments every cycle, saturates at all-ones.
//   Budget decrements only on cycles with registered stall==0; at budget reaching 0 -> DRAIN.
//  redirect_valid in RUN: next cycle pc_override_valid=1 for one cycle, pc_override=redirect_pc;
//   pc_override holds last value afterwards. Redirect outside RUN ignored. Redirect beats stall:
//   on the pulse cycle stall is forced 0. Back-to-back redirects yield back-to-back pulses.
//  DRAIN: stall=1 for DRAIN_CYCLES cycles, redirects ignored, then DONE.
//  DONE: core_rst=1, stall=0, done=1; cycle_cnt frozen. start -> RESET, clears done/aborted.
//  abort in RESET/RUN/DRAIN -> DONE next cycle with aborted=1 (skips drain). abort in IDLE/DONE ignored.
//  abort and start same cycle: abort wins in busy states; start wins in DONE.
//  start while busy ignored. Budget exactly 1: one unstalled RUN cycle then DRAIN.
// CONFIGURATION
//  QU_RUN_CTRL_STALL_STATS_EN defined: adds output stall_cnt [NUM_STALL_SRC][CNT_WIDTH]; entry i
//   counts RUN cycles with stall_req[i]==1, saturating, cleared on entry to RESET and by rst.
//  Undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  qu_common: run_ctrl_state_t enum {IDLE, RESET, RUN, DRAIN, DONE}, QU_RUN_CNT_WIDTH constant.
//  Sub-module qu_sat_counter (WIDTH param; clr, inc -> cnt) for cycle_cnt and stall_cnt entries.
//  Budget/reset/drain counters share one down-counter reloaded on state entry.
// TESTING
//  Reset then start, cfg_run_cycles=0 -> core_rst high 5 cycles, RUN 20 cycles, stall 2, done=1, cycle_cnt=20.
//  cfg_run_cycles=10, stall_req=4'b0100 for 3 RUN cycles -> RUN lasts 13 cycles, cycle_cnt=13, done=1.
//  redirect_valid with redirect_pc=32'h0000_0100 in RUN while stall_req=4'b0001 -> pc_override_valid 1 cycle, stall=0 that cycle.
//  abort on 4th RUN cycle -> next cycle done=1, aborted=1, core_rst=1, no DRAIN stall.
//  rst low during RUN -> next cycle IDLE, all outputs at reset values; start then repeats full sequence.
//  With QU_RUN_CTRL_STALL_STATS_EN: stall_req[1] high 7 RUN cycles -> stall_cnt[1]=7, others 0.

Source files
------------

// File: rtl/qu_common_pkg.sv
// Shared types for the qu run controller: run phase encoding and default counter width.
package qu_common;

  localparam int unsigned QU_RUN_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    DRAIN,
    DONE
  } run_ctrl_state_t;

endpackage

// File: rtl/qu_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module qu_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/qu_run_ctrl.sv
// Run controller for qu_core: reset hold, budgeted run with merged stalls, PC redirects, drain, done/abort.
// Optional per-source stall statistics port when QU_RUN_CTRL_STALL_STATS_EN is defined.
module qu_run_ctrl
  import qu_common::*;
#(
  parameter int unsigned PC_WIDTH      = 32,
  parameter int unsigned NUM_STALL_SRC = 4,
  parameter int unsigned RST_CYCLES    = 5,
  parameter int unsigned RUN_CYCLES    = 20,
  parameter int unsigned DRAIN_CYCLES  = 2,
  parameter int unsigned CNT_WIDTH     = QU_RUN_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNT_WIDTH-1:0]     cfg_run_cycles,
  input  logic [NUM_STALL_SRC-1:0] stall_req,
  input  logic                     redirect_valid,
  input  logic [PC_WIDTH-1:0]      redirect_pc,
  output logic                     core_rst,
  output logic                     stall,
  output logic                     pc_override_valid,
  output logic [PC_WIDTH-1:0]      pc_override,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [CNT_WIDTH-1:0]     cycle_cnt
`ifdef QU_RUN_CTRL_STALL_STATS_EN
  ,
  output logic [NUM_STALL_SRC-1:0][CNT_WIDTH-1:0] stall_cnt
`endif
);

  localparam logic [CNT_WIDTH-1:0] RST_LOAD   = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RUN_LOAD   = CNT_WIDTH'(RUN_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD = CNT_WIDTH'(DRAIN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  run_ctrl_state_t       state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  budget_q;
  logic                  core_rst_q;
  logic                  stall_q;
  logic                  pc_valid_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  aborted_q;

  logic enter_reset_d;
  logic in_run_d;

  assign enter_reset_d = start && ((state_q == IDLE) || (state_q == DONE));
  assign in_run_d      = (state_q == RUN);

  // cnt_q is shared: RESET hold, RUN budget and DRAIN length, reloaded on each state entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      budget_q   <= '0;
      core_rst_q <= 1'b1;
      stall_q    <= 1'b0;
      pc_valid_q <= 1'b0;
      pc_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      pc_valid_q <= 1'b0;
      if (abort && busy_q) begin
        state_q    <= DONE;
        core_rst_q <= 1'b1;
        stall_q    <= 1'b0;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        aborted_q  <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            if (start) begin
              state_q    <= RESET;
              cnt_q      <= RST_LOAD;
              budget_q   <= (cfg_run_cycles == '0) ? RUN_LOAD : cfg_run_cycles;
              core_rst_q <= 1'b1;
              stall_q    <= 1'b0;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
              aborted_q  <= 1'b0;
            end
          end
          RESET: begin
            if (cnt_q == '0) begin
              state_q    <= RUN;
              cnt_q      <= budget_q;
              core_rst_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          RUN: begin
            // Only cycles the core actually ran unstalled consume budget.
            if (!stall_q && (cnt_q == CNT_ONE)) begin
              state_q <= DRAIN;
              cnt_q   <= DRAIN_LOAD;
              stall_q <= 1'b1;
            end else begin
              if (!stall_q) begin
                cnt_q <= cnt_q - 1'b1;
              end
              if (redirect_valid) begin
                pc_valid_q <= 1'b1;
                pc_q       <= redirect_pc;
                stall_q    <= 1'b0;
              end else begin
                stall_q <= |stall_req;
              end
            end
          end
          DRAIN: begin
            if (cnt_q == '0) begin
              state_q    <= DONE;
              core_rst_q <= 1'b1;
              stall_q    <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  qu_sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (enter_reset_d),
    .inc (in_run_d),
    .cnt (cycle_cnt)
  );

`ifdef QU_RUN_CTRL_STALL_STATS_EN
  for (genvar i = 0; i < NUM_STALL_SRC; i++) begin : g_stall_stat
    qu_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .clr (enter_reset_d),
      .inc (in_run_d && stall_req[i]),
      .cnt (stall_cnt[i])
    );
  end
`endif

  assign core_rst          = core_rst_q;
  assign stall             = stall_q;
  assign pc_override_valid = pc_valid_q;
  assign pc_override       = pc_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign aborted           = aborted_q;

endmodule

// File: tb/tb_qu_run_ctrl.sv
// Bench for qu_run_ctrl: directed vector table, then random traffic against a phase-level model.
module tb_qu_run_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] cfg_run_cycles;
  logic [3:0]  stall_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        core_rst;
  logic        stall;
  logic        pc_override_valid;
  logic [31:0] pc_override;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] cycle_cnt;
`ifdef QU_RUN_CTRL_STALL_STATS_EN
  logic [3:0][15:0] stall_cnt;
`endif

  qu_run_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .cfg_run_cycles    (cfg_run_cycles),
    .stall_req         (stall_req),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .core_rst          (core_rst),
    .stall             (stall),
    .pc_override_valid (pc_override_valid),
    .pc_override       (pc_override),
    .busy              (busy),
    .done              (done),
    .aborted           (aborted),
    .cycle_cnt         (cycle_cnt)
`ifdef QU_RUN_CTRL_STALL_STATS_EN
    ,
    .stall_cnt         (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // ctrl bit order: {core_rst, stall, pc_override_valid, busy, done, aborted}
  typedef struct {
    logic        r;
    logic        s;
    logic        a;
    logic [15:0] cfg;
    logic [3:0]  sr;
    logic        rv;
    logic [31:0] rpc;
    int          reps;
    logic [5:0]  ctrl;
    logic [31:0] pc;
    int          cyc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic a, input logic [15:0] cfg,
                              input logic [3:0] sr, input logic rv, input logic [31:0] rpc,
                              input int reps, input logic [5:0] ctrl, input logic [31:0] pc,
                              input int cyc);
    vec_t v;
    v.r = r; v.s = s; v.a = a; v.cfg = cfg; v.sr = sr; v.rv = rv; v.rpc = rpc;
    v.reps = reps; v.ctrl = ctrl; v.pc = pc; v.cyc = cyc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic a, input logic [15:0] c,
                       input logic [3:0] sr, input logic v, input logic [31:0] p);
    rst = r; start = s; abort = a; cfg_run_cycles = c;
    stall_req = sr; redirect_valid = v; redirect_pc = p;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ctrl_bits();
    return {core_rst, stall, pc_override_valid, busy, done, aborted};
  endfunction

  // Phase-level reference: tracks elapsed cycles per phase and budget consumed.
  localparam int PH_IDLE = 0, PH_RESET = 1, PH_RUN = 2, PH_DRAIN = 3, PH_DONE = 4;
  localparam int CMAX = 65535;
  int          m_ph, m_age, m_budget, m_used;
  logic        e_core_rst, e_stall, e_pov, e_busy, e_done, e_aborted;
  logic [31:0] e_pc;
  int          e_cyc;
  int          e_scnt[4];

  task automatic m_finish(input logic ab);
    m_ph = PH_DONE; e_core_rst = 1'b1; e_stall = 1'b0;
    e_busy = 1'b0; e_done = 1'b1; e_aborted = ab;
  endtask

  task automatic m_edge(input logic r, input logic s, input logic a, input logic [15:0] cfg,
                        input logic [3:0] sr, input logic rv, input logic [31:0] rpc);
    e_pov = 1'b0;
    if (!r) begin
      m_ph = PH_IDLE; e_core_rst = 1'b1; e_stall = 1'b0; e_pc = '0;
      e_busy = 1'b0; e_done = 1'b0; e_aborted = 1'b0; e_cyc = 0;
      for (int i = 0; i < 4; i++) e_scnt[i] = 0;
    end else if (m_ph == PH_IDLE || m_ph == PH_DONE) begin
      if (s) begin
        m_ph = PH_RESET; m_age = 0;
        m_budget = (cfg == 16'd0) ? 20 : int'(cfg);
        e_cyc = 0;
        for (int i = 0; i < 4; i++) e_scnt[i] = 0;
        e_core_rst = 1'b1; e_stall = 1'b0; e_busy = 1'b1; e_done = 1'b0; e_aborted = 1'b0;
      end
    end else if (m_ph == PH_RESET) begin
      if (a) m_finish(1'b1);
      else begin
        m_age++;
        if (m_age == 5) begin m_ph = PH_RUN; m_used = 0; e_core_rst = 1'b0; end
      end
    end else if (m_ph == PH_RUN) begin
      if (e_cyc < CMAX) e_cyc++;
      for (int i = 0; i < 4; i++) if (sr[i] && e_scnt[i] < CMAX) e_scnt[i]++;
      if (a) m_finish(1'b1);
      else begin
        if (!e_stall) m_used++;
        if (m_used == m_budget) begin m_ph = PH_DRAIN; m_age = 0; e_stall = 1'b1; end
        else if (rv) begin e_pov = 1'b1; e_pc = rpc; e_stall = 1'b0; end
        else e_stall = |sr;
      end
    end else begin
      if (a) m_finish(1'b1);
      else begin
        m_age++;
        if (m_age == 2) m_finish(1'b0);
      end
    end
  endtask

  localparam logic [5:0] C_IDLE = 6'b100000, C_RST = 6'b100100, C_RUN = 6'b000100,
                         C_STL = 6'b010100, C_PLS = 6'b001100, C_DONE = 6'b100010,
                         C_ABT = 6'b100011;

  initial begin
    vec_t tbl[$];
    logic        r, s, a, v;
    logic [15:0] c;
    logic [3:0]  sr;
    logic [31:0] p;

    // Default budget run, with abort in IDLE and redirect in DRAIN ignored
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,          2, C_IDLE, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0,          1, C_IDLE, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,          1, C_RST,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,          4, C_RST,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,         20, C_RUN,  0, 19));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'hdead,   2, C_STL,  0, 20));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,          2, C_DONE, 0, 20));
    // Budget 10 with three stalled cycles; start while busy ignored
    tbl.push_back(mk(1, 1, 0, 10, 0, 0, 0,         1, C_RST,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,          4, C_RST,  0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,          1, C_RUN,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'b0100, 0, 0,    3, C_STL,  0, 3));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,          9, C_RUN,  0, 12));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,          2, C_STL,  0, 13));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,          1, C_DONE, 0, 13));
    // Redirect beats stall, then abort on the 4th RUN cycle
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,          1, C_RST,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,          4, C_RST,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'b0001, 0, 0,    1, C_RUN,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'b0001, 0, 0,    1, C_STL,  0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'b0001, 1, 32'h100, 1, C_PLS, 32'h100, 2));
    tbl.push_back(mk(1, 0, 0, 0, 4'b0001, 0, 0,    1, C_STL,  32'h100, 3));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0,          1, C_ABT,  32'h100, 4));
    // Start beats abort in DONE; back-to-back redirects; rst mid-run
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0,          1, C_RST,  32'h100, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,          4, C_RST,  32'h100, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h200,    1, C_RUN,  32'h100, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h200,    1, C_PLS,  32'h200, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'b1000, 1, 32'h300, 1, C_PLS, 32'h300, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,          1, C_IDLE, 0, 0));
    // Budget of exactly one
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0,          1, C_RST,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,          4, C_RST,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,          1, C_RUN,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,          2, C_STL,  0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,          1, C_DONE, 0, 1));
    // Abort beats start while in RESET
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0,          1, C_RST,  0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0,          1, C_ABT,  0, 0));

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        drive(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].cfg, tbl[i].sr, tbl[i].rv, tbl[i].rpc);
        chk($sformatf("row%0d.%0d ctrl", i, k), 64'(ctrl_bits()), 64'(tbl[i].ctrl));
        chk($sformatf("row%0d.%0d pc", i, k), 64'(pc_override), 64'(tbl[i].pc));
      end
      chk($sformatf("row%0d cycle_cnt", i), 64'(cycle_cnt), 64'(tbl[i].cyc));
    end

    // Random traffic against the model; first cycle resets both
    for (int n = 0; n < 4000; n++) begin
      r  = (n == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
      s  = ($urandom_range(0, 19) == 0);
      a  = ($urandom_range(0, 49) == 0);
      c  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      sr = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      v  = ($urandom_range(0, 6) == 0);
      p  = $urandom;
      drive(r, s, a, c, sr, v, p);
      m_edge(r, s, a, c, sr, v, p);
      chk($sformatf("rnd%0d ctrl", n), 64'(ctrl_bits()),
          64'({e_core_rst, e_stall, e_pov, e_busy, e_done, e_aborted}));
      chk($sformatf("rnd%0d pc", n), 64'(pc_override), 64'(e_pc));
      chk($sformatf("rnd%0d cycle_cnt", n), 64'(cycle_cnt), 64'(e_cyc));
`ifdef QU_RUN_CTRL_STALL_STATS_EN
      for (int i = 0; i < 4; i++)
        chk($sformatf("rnd%0d stall_cnt%0d", n, i), 64'(stall_cnt[i]), 64'(e_scnt[i]));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
